// File: rtl/button_renderer.sv
// Draws one bevelled square button per frame over the incoming raster and
// hands a done_x/done_y pulse back to the board sequencer after each frame.
module button_renderer #(
    parameter logic [11:0] FILL_RGB   = 12'h888,
    parameter logic [11:0] EDGE_RGB   = 12'hFFF,
    parameter logic [11:0] SHADOW_RGB = 12'h444
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        draw_button,
    input  logic [10:0] button_xpos,
    input  logic [10:0] button_ypos,
    input  logic [6:0]  button_size,
    input  logic [4:0]  button_num,
    input  logic [10:0] vcount_in,
    input  logic [10:0] hcount_in,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        vblnk_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] vcount_out,
    output logic [10:0] hcount_out,
    output logic        vsync_out,
    output logic        hsync_out,
    output logic        vblnk_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out,
    output logic        done_x,
    output logic        done_y
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RENDER,
        S_PULSE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_vblnk_prev;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic [6:0]  r_size;
    logic [4:0]  r_num;
    logic [4:0]  r_col;
    logic [4:0]  w_col_next;
    logic        w_latch;
    logic        w_pulse;
    logic        r_done_x;
    logic        r_done_y;

    logic        w_frame_start;
    logic        w_frame_end;
    logic        w_last_col;

    assign w_frame_start = (vcount_in == 11'd0) && (hcount_in == 11'd0);
    assign w_frame_end   = vblnk_in && !r_vblnk_prev;
    assign w_last_col    = (r_num == 5'd0) || (r_col == r_num - 5'd1);

    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_pulse    = 1'b0;
        w_col_next = r_col;
        case (r_state)
            S_IDLE: begin
                w_col_next = 5'd0;
                if (draw_button) w_next = S_ARM;
            end
            S_ARM: begin
                if (w_frame_start) begin
                    w_latch = 1'b1;
                    w_next  = S_RENDER;
                end
            end
            S_RENDER: begin
                if (w_frame_end) begin
                    w_pulse = 1'b1;
                    w_next  = S_PULSE;
                end
            end
            S_PULSE: begin
                w_col_next = w_last_col ? 5'd0 : r_col + 5'd1;
                w_next     = S_ARM;
            end
            default: w_next = S_IDLE;
        endcase
        // Losing the request anywhere outside IDLE aborts the button silently.
        if (r_state != S_IDLE && !draw_button) begin
            w_next     = S_IDLE;
            w_latch    = 1'b0;
            w_pulse    = 1'b0;
            w_col_next = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vblnk_prev <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_size       <= '0;
            r_num        <= '0;
            r_col        <= '0;
            r_done_x     <= 1'b0;
            r_done_y     <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_vblnk_prev <= vblnk_in;
            r_col        <= w_col_next;
            r_done_x     <= w_pulse;
            r_done_y     <= w_pulse && w_last_col;
            if (w_latch) begin
                r_x    <= button_xpos;
                r_y    <= button_ypos;
                r_size <= button_size;
                r_num  <= button_num;
            end
        end
    end

    assign done_x = r_done_x;
    assign done_y = r_done_y;

    // Geometry is compared at 12 bits so x+size near the right edge cannot wrap.
    logic [11:0] w_h12;
    logic [11:0] w_v12;
    logic [11:0] w_x12;
    logic [11:0] w_y12;
    logic [11:0] w_xe;
    logic [11:0] w_ye;
    logic        w_active;
    logic        w_inside;
    logic        w_edge;
    logic        w_shadow;

    assign w_h12    = {1'b0, hcount_in};
    assign w_v12    = {1'b0, vcount_in};
    assign w_x12    = {1'b0, r_x};
    assign w_y12    = {1'b0, r_y};
    assign w_xe     = w_x12 + {5'd0, r_size};
    assign w_ye     = w_y12 + {5'd0, r_size};
    assign w_active = (r_state == S_RENDER) && !hblnk_in && !vblnk_in;
    assign w_inside = w_active &&
                      (w_h12 >= w_x12) && (w_h12 < w_xe) &&
                      (w_v12 >= w_y12) && (w_v12 < w_ye);
    assign w_edge   = (w_h12 == w_x12) || (w_v12 == w_y12);
    assign w_shadow = (w_h12 == w_xe - 12'd1) || (w_v12 == w_ye - 12'd1);

    logic [10:0] r_s1_vcount;
    logic [10:0] r_s1_hcount;
    logic        r_s1_vsync;
    logic        r_s1_hsync;
    logic        r_s1_vblnk;
    logic        r_s1_hblnk;
    logic [11:0] r_s1_rgb;
    logic        r_s1_inside;
    logic        r_s1_edge;
    logic        r_s1_shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vcount <= '0;
            r_s1_hcount <= '0;
            r_s1_vsync  <= 1'b0;
            r_s1_hsync  <= 1'b0;
            r_s1_vblnk  <= 1'b0;
            r_s1_hblnk  <= 1'b0;
            r_s1_rgb    <= '0;
            r_s1_inside <= 1'b0;
            r_s1_edge   <= 1'b0;
            r_s1_shadow <= 1'b0;
        end else begin
            r_s1_vcount <= vcount_in;
            r_s1_hcount <= hcount_in;
            r_s1_vsync  <= vsync_in;
            r_s1_hsync  <= hsync_in;
            r_s1_vblnk  <= vblnk_in;
            r_s1_hblnk  <= hblnk_in;
            r_s1_rgb    <= rgb_in;
            r_s1_inside <= w_inside;
            r_s1_edge   <= w_edge;
            r_s1_shadow <= w_shadow;
        end
    end

    logic [11:0] w_rgb_mux;

    always_comb begin
        w_rgb_mux = r_s1_rgb;
        if (r_s1_inside) begin
            if (r_s1_edge)        w_rgb_mux = EDGE_RGB;
            else if (r_s1_shadow) w_rgb_mux = SHADOW_RGB;
            else                  w_rgb_mux = FILL_RGB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vcount_out <= '0;
            hcount_out <= '0;
            vsync_out  <= 1'b0;
            hsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            vcount_out <= r_s1_vcount;
            hcount_out <= r_s1_hcount;
            vsync_out  <= r_s1_vsync;
            hsync_out  <= r_s1_hsync;
            vblnk_out  <= r_s1_vblnk;
            hblnk_out  <= r_s1_hblnk;
            rgb_out    <= w_rgb_mux;
        end
    end

endmodule

// File: tb/tb_button_renderer.sv
// Scoreboard bench for button_renderer: directed pixels and frame events push
// expected results stamped with the cycle they must appear; a monitor checks them.
module tb_button_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        draw_button = 1'b0;
    logic [10:0] button_xpos = '0;
    logic [10:0] button_ypos = '0;
    logic [6:0]  button_size = '0;
    logic [4:0]  button_num = 5'd3;
    logic [10:0] vcount_in = '0;
    logic [10:0] hcount_in = '0;
    logic        vsync_in = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic        hblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [10:0] vcount_out;
    logic [10:0] hcount_out;
    logic        vsync_out;
    logic        hsync_out;
    logic        vblnk_out;
    logic        hblnk_out;
    logic [11:0] rgb_out;
    logic        done_x;
    logic        done_y;

    button_renderer dut (
        .clk(clk), .rst(rst), .draw_button(draw_button),
        .button_xpos(button_xpos), .button_ypos(button_ypos),
        .button_size(button_size), .button_num(button_num),
        .vcount_in(vcount_in), .hcount_in(hcount_in),
        .vsync_in(vsync_in), .hsync_in(hsync_in),
        .vblnk_in(vblnk_in), .hblnk_in(hblnk_in), .rgb_in(rgb_in),
        .vcount_out(vcount_out), .hcount_out(hcount_out),
        .vsync_out(vsync_out), .hsync_out(hsync_out),
        .vblnk_out(vblnk_out), .hblnk_out(hblnk_out), .rgb_out(rgb_out),
        .done_x(done_x), .done_y(done_y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int K_PIX  = 0;
    localparam int K_DONE = 1;
    localparam int K_RST  = 2;

    typedef struct {
        int          stamp;
        int          kind;
        logic [38:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input int stamp, input int kind, input logic [38:0] e, input string name);
        exp_t r;
        r.stamp = stamp;
        r.kind  = kind;
        r.exp   = e;
        r.name  = name;
        q.push_back(r);
    endtask

    task automatic rstcyc();
        @(negedge clk);
        rst = 1'b1;
        hcount_in = 11'd10; vcount_in = 11'd10; rgb_in = 12'h555;
        hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
        push(cyc + 1, K_RST, '0, "reset");
    endtask

    // Active-video pixel; when chk is set the rendered colour is expected 2 cycles later.
    task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                       input logic hb, input logic chk, input logic [11:0] exp_rgb,
                       input string name);
        @(negedge clk);
        rst = 1'b0;
        hcount_in = h; vcount_in = v; rgb_in = rgb;
        hsync_in = h[0]; vsync_in = v[0]; hblnk_in = hb; vblnk_in = 1'b0;
        if (chk)
            push(cyc + 2, K_PIX, {v, h, v[0], h[0], 1'b0, hb, exp_rgb}, name);
    endtask

    task automatic setc(input logic d, input logic [10:0] x, input logic [10:0] y,
                        input logic [6:0] s);
        @(negedge clk);
        draw_button = d; button_xpos = x; button_ypos = y; button_size = s;
        hcount_in = 11'd5; vcount_in = 11'd5; rgb_in = 12'h000;
        hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    endtask

    task automatic fstart();
        pix(11'd0, 11'd0, 12'h000, 1'b0, 1'b0, 12'h000, "");
    endtask

    task automatic fend(input logic [1:0] exp_done, input string name);
        @(negedge clk);
        hcount_in = 11'd0; vcount_in = 11'd600; rgb_in = 12'h000;
        hblnk_in = 1'b1; vblnk_in = 1'b1;
        push(cyc + 1, K_DONE, {37'd0, exp_done}, name);
        @(negedge clk);
        hcount_in = 11'd1;
    endtask

    always @(negedge clk) begin
        logic        dchk;
        logic [38:0] act;
        exp_t        e;
        dchk = 1'b0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].stamp <= cyc) begin
                e = q[i];
                q.delete(i);
                checks++;
                case (e.kind)
                    K_PIX:  act = {vcount_out, hcount_out, vsync_out, hsync_out,
                                   vblnk_out, hblnk_out, rgb_out};
                    K_DONE: begin act = {37'd0, done_x, done_y}; dchk = 1'b1; end
                    default: begin
                        act = {vcount_out, hcount_out, vsync_out, hsync_out,
                               vblnk_out, hblnk_out, rgb_out, done_x, done_y};
                        dchk = 1'b1;
                    end
                endcase
                if (e.stamp != cyc || act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: cycle %0d (due %0d) got %h expected %h",
                             e.name, cyc, e.stamp, act, e.exp);
                end
            end
        end
        if (!rst && !dchk && (done_x === 1'b1 || done_y === 1'b1)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: cycle %0d got done_x=%b done_y=%b expected 0 0",
                     cyc, done_x, done_y);
        end
    end

    initial begin
        repeat (3) rstcyc();
        pix(11'd5, 11'd5, 12'hABC, 1'b0, 1'b1, 12'hABC, "reset_pass");

        // Frame 1: single button at (100,50) size 20, col 0
        setc(1'b1, 11'd100, 11'd50, 7'd20);
        fstart();
        pix(11'd100, 11'd50, 12'h123, 1'b0, 1'b1, 12'hFFF, "top_left");
        pix(11'd119, 11'd50, 12'h123, 1'b0, 1'b1, 12'hFFF, "top_right");
        pix(11'd119, 11'd60, 12'h123, 1'b0, 1'b1, 12'h444, "right_shadow");
        pix(11'd110, 11'd60, 12'h123, 1'b0, 1'b1, 12'h888, "fill");
        pix(11'd120, 11'd60, 12'h123, 1'b0, 1'b1, 12'h123, "right_outside");
        pix(11'd100, 11'd69, 12'h123, 1'b0, 1'b1, 12'hFFF, "left_over_bottom");
        pix(11'd110, 11'd69, 12'h123, 1'b0, 1'b1, 12'h444, "bottom_shadow");
        pix(11'd110, 11'd70, 12'h123, 1'b0, 1'b1, 12'h123, "below");
        pix(11'd110, 11'd60, 12'h123, 1'b1, 1'b1, 12'h123, "hblank_pass");
        fend(2'b10, "f1_done");
        // Frames 2-4: row wrap with button_num=3
        fstart();
        pix(11'd110, 11'd60, 12'h123, 1'b0, 1'b1, 12'h888, "f2_fill");
        fend(2'b10, "f2_done");
        fstart();
        fend(2'b11, "f3_done_y");
        fstart();
        fend(2'b10, "f4_restart");
        // Frames 5-6: geometry changed mid-frame only takes effect next frame
        fstart();
        pix(11'd100, 11'd50, 12'h123, 1'b0, 1'b1, 12'hFFF, "latch_old");
        setc(1'b1, 11'd300, 11'd50, 7'd20);
        pix(11'd100, 11'd50, 12'h123, 1'b0, 1'b1, 12'hFFF, "latch_keep");
        pix(11'd300, 11'd50, 12'h123, 1'b0, 1'b1, 12'h123, "latch_notyet");
        fend(2'b10, "f5_done");
        fstart();
        pix(11'd300, 11'd50, 12'h123, 1'b0, 1'b1, 12'hFFF, "latch_new");
        pix(11'd100, 11'd50, 12'h123, 1'b0, 1'b1, 12'h123, "latch_oldgone");
        fend(2'b11, "f6_done_y");
        // Frame 7 moves col to 1, frame 8 aborts
        fstart();
        fend(2'b10, "f7_done");
        fstart();
        pix(11'd300, 11'd50, 12'h123, 1'b0, 1'b1, 12'hFFF, "abort_before");
        setc(1'b0, 11'd300, 11'd50, 7'd20);
        pix(11'd302, 11'd50, 12'h123, 1'b0, 1'b1, 12'h123, "abort_pass");
        fend(2'b00, "abort_nopulse");
        // Re-armed: col restarts at 0, so done_y lands on the third frame
        setc(1'b1, 11'd300, 11'd50, 7'd20);
        fstart();
        pix(11'd305, 11'd55, 12'h123, 1'b0, 1'b1, 12'h888, "rearm_fill");
        fend(2'b10, "rearm_c0");
        fstart();
        fend(2'b10, "rearm_c1");
        fstart();
        fend(2'b11, "rearm_c2");
        // Degenerate sizes and right-edge geometry
        setc(1'b1, 11'd300, 11'd50, 7'd0);
        fstart();
        pix(11'd300, 11'd50, 12'h123, 1'b0, 1'b1, 12'h123, "size0_none");
        fend(2'b10, "size0_done");
        setc(1'b1, 11'd300, 11'd50, 7'd1);
        fstart();
        pix(11'd300, 11'd50, 12'h123, 1'b0, 1'b1, 12'hFFF, "size1_pixel");
        pix(11'd301, 11'd50, 12'h123, 1'b0, 1'b1, 12'h123, "size1_right");
        pix(11'd300, 11'd51, 12'h123, 1'b0, 1'b1, 12'h123, "size1_below");
        fend(2'b10, "size1_done");
        setc(1'b1, 11'd1040, 11'd50, 7'd127);
        fstart();
        pix(11'd1040, 11'd50, 12'h123, 1'b0, 1'b1, 12'hFFF, "far_edge");
        pix(11'd1166, 11'd60, 12'h123, 1'b0, 1'b1, 12'h444, "far_shadow");
        pix(11'd1100, 11'd60, 12'h123, 1'b0, 1'b1, 12'h888, "far_fill");
        pix(11'd1039, 11'd60, 12'h123, 1'b0, 1'b1, 12'h123, "far_left");
        pix(11'd1167, 11'd60, 12'h123, 1'b0, 1'b1, 12'h123, "far_right");
        pix(11'd10, 11'd60, 12'h123, 1'b0, 1'b1, 12'h123, "far_nowrap");
        fend(2'b11, "far_done_y");

        repeat (5) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
